layer1_neuron_mac: RTL and testbench

//  Downstream consumer of the layer-1 weight SRAM. Per handshake, takes one 98-lane chunk of Q8.8

---
 rtl/layer1_neuron_mac.sv | 161 ++++++++++++++++
 tb/tb_layer1_neuron_mac.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : layer1_neuron_mac
// Summary  : Layer-1 neuron MAC. Multiplies 98 lanes per chunk, accumulates 8 chunks,
//            then adds bias, applies ReLU and saturates to one Q8.8 activation.
// Revision : 1.0 - initial release
// ============================================================================
module layer1_neuron_mac #(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int LANES   = 98,
  parameter int CHUNKS  = 8,
  parameter int NEURONS = 200,
  parameter int ACC_W   = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   w_bus,
  input  logic [LANES*W-1:0]   x_bus,
  input  logic [W-1:0]         bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [7:0]           out_idx,
  output logic                 layer_done
);

  localparam int CNT_W = $clog2(CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (W - 1)) - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic                     ready_en;
  logic [CNT_W-1:0]         chunk_cnt;
  logic signed [2*W-1:0]    prod_comb [LANES];
  logic signed [2*W-1:0]    prod_q    [LANES];
  logic signed [ACC_W-1:0]  tree_sum;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  y;
  logic [W-1:0]             bias_q;
  logic [W-1:0]             result;
  logic                     v1, v2;
  logic                     last1, last2, last3;
  logic                     accept;
  logic                     out_fire;

  // ready_en keeps in_ready low while rst is held and until the first edge after release.
  assign in_ready   = ready_en && (state == ST_ACCUM);
  assign accept     = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign layer_done = out_fire && (out_idx == 8'(NEURONS));

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign prod_comb[i] = $signed(w_bus[W*i +: W]) * $signed(x_bus[W*i +: W]);
    end
  endgenerate

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + {{(ACC_W-2*W){prod_q[i][2*W-1]}}, prod_q[i]};
    end
  end

  // Datapath registers are qualified by the pipeline valids, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= prod_comb[i];
      end
    end
    if (v1) begin
      sum_q <= tree_sum;
    end
  end

  assign biased = acc + ({{(ACC_W-W){bias_q[W-1]}}, bias_q} <<< FRAC);
  assign y      = biased >>> FRAC;

  always_comb begin
    result = y[W-1:0];
    if (y[ACC_W-1]) begin
      result = '0;
    end else if (y > Y_MAX) begin
      result = Y_MAX[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      chunk_cnt <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      last3     <= 1'b0;
      acc       <= '0;
      bias_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 8'd1;
    end else begin
      ready_en <= 1'b1;
      v1       <= accept;
      last1    <= accept && (chunk_cnt == LAST_CHUNK);
      v2       <= v1;
      last2    <= last1;
      last3    <= last2;
      if (accept) begin
        chunk_cnt <= chunk_cnt + 1'b1;
        if (chunk_cnt == '0) begin
          bias_q <= bias;
        end
      end
      if (out_fire) begin
        acc       <= '0;
        chunk_cnt <= '0;
        out_valid <= 1'b0;
        out_idx   <= (out_idx == 8'(NEURONS)) ? 8'd1 : out_idx + 8'd1;
      end else if (v2) begin
        acc <= acc + sum_q;
      end
      if ((state == ST_DRAIN) && last3) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (accept && (chunk_cnt == LAST_CHUNK)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last3) state_nxt = ST_OUT;
      ST_OUT:   if (out_fire) state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_layer1_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer1_neuron_mac
// Summary  : Randomized self-checking bench for layer1_neuron_mac with an
//            arithmetic reference model of the neuron activation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer1_neuron_mac;

  localparam int W       = 16;
  localparam int LANES   = 98;
  localparam int CHUNKS  = 8;
  localparam int NEURONS = 200;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] w_bus;
  logic [LANES*W-1:0] x_bus;
  logic [W-1:0]       bias;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [7:0]         out_idx;
  logic               layer_done;

  int      checks    = 0;
  int      errors    = 0;
  int      ld_pulses = 0;
  shortint wts [CHUNKS][LANES];
  shortint pix [CHUNKS][LANES];

  always #5 clk = ~clk;

  layer1_neuron_mac dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w_bus      (w_bus),
    .x_bus      (x_bus),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .layer_done (layer_done)
  );

  always @(negedge clk) if (layer_done) ld_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Activation = floor((sum of products + bias*2^8) / 2^8), ReLU, clamp to 0x7FFF.
  function automatic logic [15:0] model(input shortint b);
    longint s;
    s = 0;
    for (int c = 0; c < CHUNKS; c++)
      for (int l = 0; l < LANES; l++)
        s += longint'(wts[c][l]) * longint'(pix[c][l]);
    s = s + longint'(b) * 256;
    s = s >>> 8;
    if (s < 0) return 16'h0000;
    if (s > 32767) return 16'h7FFF;
    return s[15:0];
  endfunction

  task automatic clear_data();
    for (int c = 0; c < CHUNKS; c++)
      for (int l = 0; l < LANES; l++) begin
        wts[c][l] = 0;
        pix[c][l] = 0;
      end
  endtask

  task automatic fill_random(input int mode);
    for (int c = 0; c < CHUNKS; c++)
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          0: begin
            wts[c][l] = shortint'($urandom);
            pix[c][l] = shortint'($urandom);
          end
          1: begin
            wts[c][l] = shortint'(int'($urandom_range(0, 255)) - 128);
            pix[c][l] = shortint'(int'($urandom_range(0, 255)) - 128);
          end
          2: begin
            wts[c][l] = shortint'($urandom_range(0, 255));
            pix[c][l] = shortint'($urandom_range(0, 63));
          end
          default: begin
            wts[c][l] = ($urandom_range(0, 31) == 0) ? shortint'($urandom) : shortint'(0);
            pix[c][l] = shortint'($urandom);
          end
        endcase
      end
  endtask

  task automatic send_chunks(input logic [15:0] b, input int nch, output int stalls);
    stalls = 0;
    bias = b;
    for (int c = 0; c < nch; c++) begin
      for (int l = 0; l < LANES; l++) begin
        w_bus[W*l +: W] = wts[c][l];
        x_bus[W*l +: W] = pix[c][l];
      end
      in_valid = 1'b1;
      while (!in_ready && stalls < 50) begin
        tick();
        stalls++;
      end
      tick();
      bias = W'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic get_output(input string tag, input logic [15:0] exp_data,
                            input int exp_idx, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " valid"}, out_valid, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, out_data, exp_data);
    check({tag, " idx"}, out_idx, exp_idx);
  endtask

  task automatic handshake(input string tag, input int exp_idx);
    out_ready = 1'b1;
    check({tag, " layer_done"}, layer_done, (exp_idx == NEURONS));
    tick();
    check({tag, " valid low"}, out_valid, 0);
  endtask

  task automatic random_neuron(input int exp_idx, inout int total_stalls);
    shortint b;
    int      st;
    logic [15:0] exp;
    fill_random($urandom_range(0, 3));
    b = ($urandom_range(0, 1) == 1) ? shortint'($urandom) :
                                      shortint'(int'($urandom_range(0, 8191)) - 4096);
    exp = model(b);
    send_chunks(b, CHUNKS, st);
    total_stalls += st;
    get_output("rand", exp, exp_idx, 3);
    handshake("rand", exp_idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int total_stalls;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bias      = '0;
    w_bus     = '0;
    x_bus     = '0;
    total_stalls = 0;
    tick();
    tick();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_idx", out_idx, 1);
    check("rst layer_done", layer_done, 0);
    rst = 1'b0;
    tick();
    check("post-rst in_ready", in_ready, 1);

    // Directed single-lane product with bias.
    clear_data();
    wts[0][0] = 16'sh0200;
    pix[0][0] = 16'sh0180;
    send_chunks(16'h0080, CHUNKS, st);
    check("t1 stalls", st, 0);
    get_output("t1", 16'h0380, 1, 3);
    handshake("t1", 1);

    // Negative result clipped by ReLU.
    clear_data();
    wts[3][5] = -16'sh0100;
    pix[3][5] = 16'sh0100;
    send_chunks(16'h0000, CHUNKS, st);
    get_output("t2", 16'h0000, 2, 3);
    handshake("t2", 2);

    // Every lane 1.0 x 1.0 saturates.
    for (int c = 0; c < CHUNKS; c++)
      for (int l = 0; l < LANES; l++) begin
        wts[c][l] = 16'sh0100;
        pix[c][l] = 16'sh0100;
      end
    send_chunks(16'h0000, CHUNKS, st);
    get_output("t3", 16'h7FFF, 3, 3);
    handshake("t3", 3);

    // Output back-pressure with ignored input pulses.
    begin
      logic [15:0] exp4;
      fill_random(1);
      exp4 = model(16'sd300);
      out_ready = 1'b0;
      send_chunks(16'd300, CHUNKS, st);
      get_output("t4", exp4, 4, 3);
      for (int k = 0; k < 5; k++) begin
        in_valid = k[0];
        w_bus = {LANES{16'h0101}};
        x_bus = {LANES{16'h0202}};
        tick();
        check("t4 hold valid", out_valid, 1);
        check("t4 hold data", out_data, exp4);
        check("t4 hold idx", out_idx, 4);
        check("t4 in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      handshake("t4", 4);
    end

    // Stream the remainder of the layer back-to-back.
    for (int n = 5; n <= NEURONS; n++) random_neuron(n, total_stalls);
    check("stream stalls", total_stalls, 0);
    check("layer_done pulses", ld_pulses, 1);

    // Wrap to neuron 1, then reset in the middle of neuron 4.
    for (int n = 1; n <= 3; n++) random_neuron(n, total_stalls);
    fill_random(0);
    send_chunks(16'h1234, 3, st);
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst out_valid", out_valid, 0);
    check("t6 rst out_data", out_data, 0);
    check("t6 rst out_idx", out_idx, 1);
    check("t6 rst layer_done", layer_done, 0);
    check("t6 rst in_ready", in_ready, 0);
    tick();
    tick();
    check("t6 rst held in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    check("t6 release in_ready", in_ready, 1);
    clear_data();
    wts[0][0] = 16'sh0200;
    pix[0][0] = 16'sh0180;
    send_chunks(16'h0080, CHUNKS, st);
    get_output("t6", 16'h0380, 1, 3);
    handshake("t6", 1);
    check("t6 layer_done pulses", ld_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
